// File: rtl/rv_pkg.sv
// Shared RV definitions: load funct3 codes, writeback FSM encoding, XLEN legality check.
package rv_pkg;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [0:0] WB_IDLE = 1'b0;
    localparam logic [0:0] WB_WAIT = 1'b1;

    function automatic bit xlen_ok(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction
endpackage

// File: rtl/wb_load_align.sv
// Combinational load data aligner: byte-offset shift then sign/zero extension by funct3.
module wb_load_align
    import rv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AW   = $clog2(XLEN/8)
) (
    input  logic [XLEN-1:0] i_data,
    input  logic [2:0]      i_funct3,
    input  logic [AW-1:0]   i_addr_lo,
    output logic [XLEN-1:0] o_data
);
    logic [XLEN-1:0] w_sh;

    assign w_sh = i_data >> {i_addr_lo, 3'b000};

    // Casting a signed slice up to XLEN sign-extends; at XLEN=32 LW is a plain pass.
    always_comb begin
        o_data = '0;
        case (i_funct3)
            F3_LB:   o_data = XLEN'($signed(w_sh[7:0]));
            F3_LH:   o_data = XLEN'($signed(w_sh[15:0]));
            F3_LW:   o_data = XLEN'($signed(w_sh[31:0]));
            F3_LBU:  o_data = XLEN'(w_sh[7:0]);
            F3_LHU:  o_data = XLEN'(w_sh[15:0]);
            F3_LD:   if (XLEN == 64) o_data = w_sh;
            F3_LWU:  if (XLEN == 64) o_data = XLEN'(w_sh[31:0]);
            default: o_data = '0;
        endcase
    end
endmodule

// File: rtl/writeback_stage_p.sv
// Writeback stage: result select, load wait with stall/timeout, registered regfile write port.
// Optional macro WB_INSTRET_EN adds a 64-bit retired-instruction counter on o_instret.
module writeback_stage_p
    import rv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int RADDR_W      = 5,
    parameter int LOAD_TIMEOUT = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_ce,
    input  logic [2:0]                 i_funct3,
    input  logic                       i_opcode_load,
    input  logic                       i_opcode_system,
    input  logic [$clog2(XLEN/8)-1:0]  i_addr_lo,
    input  logic [XLEN-1:0]            i_dmem_data,
    input  logic                       i_dmem_ack,
    input  logic [XLEN-1:0]            i_csr_out,
    input  logic [XLEN-1:0]            i_rd,
    input  logic                       i_wr_rd,
    input  logic [RADDR_W-1:0]         i_rd_addr,
    output logic                       o_wr_rd,
    output logic [RADDR_W-1:0]         o_rd_addr,
    output logic [XLEN-1:0]            o_rd,
    output logic                       o_stall,
    output logic                       o_flush,
    output logic                       o_load_err,
    output logic [63:0]                o_instret
);
    localparam int AW = $clog2(XLEN/8);
    localparam int CW = $clog2(LOAD_TIMEOUT+1);
    localparam logic [CW-1:0] CNT_MAX = CW'(LOAD_TIMEOUT);

    if (!xlen_ok(XLEN)) begin : g_bad_xlen
        $error("writeback_stage_p: XLEN must be 32 or 64");
    end

    logic [0:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [2:0]         r_f3;
    logic [AW-1:0]      r_alo;
    logic [RADDR_W-1:0] r_rda;
    logic               r_wr;
    logic               r_wr_rd;
    logic [RADDR_W-1:0] r_rd_addr;
    logic [XLEN-1:0]    r_rd;
    logic               r_tmo;

    logic               w_wait;
    logic [2:0]         w_f3;
    logic [AW-1:0]      w_alo;
    logic [RADDR_W-1:0] w_rda;
    logic               w_wr;
    logic [XLEN-1:0]    w_ld;
    logic [XLEN-1:0]    w_result;
    logic               w_commit;
    logic               w_timeout;
    logic               w_start;

    // In WAIT the live instruction fields belong to younger work; use the captured copy.
    assign w_wait = (r_state == WB_WAIT);
    assign w_f3   = w_wait ? r_f3  : i_funct3;
    assign w_alo  = w_wait ? r_alo : i_addr_lo;
    assign w_rda  = w_wait ? r_rda : i_rd_addr;
    assign w_wr   = w_wait ? r_wr  : i_wr_rd;

    wb_load_align #(.XLEN(XLEN), .AW(AW)) u_align (
        .i_data    (i_dmem_data),
        .i_funct3  (w_f3),
        .i_addr_lo (w_alo),
        .o_data    (w_ld)
    );

    assign w_result  = (w_wait || i_opcode_load) ? w_ld :
                       (i_opcode_system && (i_funct3 != 3'b000)) ? i_csr_out : i_rd;
    assign w_start   = !w_wait && i_ce && i_opcode_load && !i_dmem_ack;
    assign w_commit  = w_wait ? i_dmem_ack : (i_ce && !w_start);
    assign w_timeout = w_wait && !i_dmem_ack && (r_cnt == CNT_MAX);
    assign o_stall   = w_wait ? !i_dmem_ack : w_start;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= WB_IDLE;
            r_cnt     <= '0;
            r_f3      <= '0;
            r_alo     <= '0;
            r_rda     <= '0;
            r_wr      <= 1'b0;
            r_wr_rd   <= 1'b0;
            r_rd_addr <= '0;
            r_rd      <= '0;
            r_tmo     <= 1'b0;
        end else begin
            r_wr_rd <= w_commit && w_wr && (w_rda != '0);
            r_tmo   <= w_timeout;
            if (w_commit) begin
                r_rd_addr <= w_rda;
                r_rd      <= w_result;
            end
            case (r_state)
                WB_IDLE: begin
                    if (w_start) begin
                        r_state <= WB_WAIT;
                        r_cnt   <= CW'(1);
                        r_f3    <= i_funct3;
                        r_alo   <= i_addr_lo;
                        r_rda   <= i_rd_addr;
                        r_wr    <= i_wr_rd;
                    end
                end
                WB_WAIT: begin
                    if (i_dmem_ack || w_timeout) begin
                        r_state <= WB_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= WB_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_wr_rd    = r_wr_rd;
    assign o_rd_addr  = r_rd_addr;
    assign o_rd       = r_rd;
    assign o_flush    = r_tmo;
    assign o_load_err = r_tmo;

`ifdef WB_INSTRET_EN
    logic [63:0] r_instret;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_instret <= '0;
        else if (w_commit) r_instret <= r_instret + 64'd1;
    end

    assign o_instret = r_instret;
`else
    assign o_instret = '0;
`endif
endmodule

// File: tb/tb_writeback_stage_p.sv
// Bench: drives an XLEN=32 and an XLEN=64 instance in lockstep with a write scoreboard.
module tb_writeback_stage_p;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        rst, ce, ld, sys, ack, wr;
    logic [2:0]  f3, alo;
    logic [4:0]  rda;
    logic [63:0] data, csr, rdv;

    logic        o_wr32, stall32, flush32, lerr32;
    logic [4:0]  o_rda32;
    logic [31:0] o_rd32;
    logic [63:0] ir32;
    logic        o_wr64, stall64, flush64, lerr64;
    logic [4:0]  o_rda64;
    logic [63:0] o_rd64;
    logic [63:0] ir64;

    always #5 clk = ~clk;

    writeback_stage_p #(.XLEN(32), .RADDR_W(5), .LOAD_TIMEOUT(4)) u32 (
        .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_funct3(f3), .i_opcode_load(ld),
        .i_opcode_system(sys), .i_addr_lo(alo[1:0]), .i_dmem_data(data[31:0]),
        .i_dmem_ack(ack), .i_csr_out(csr[31:0]), .i_rd(rdv[31:0]), .i_wr_rd(wr),
        .i_rd_addr(rda), .o_wr_rd(o_wr32), .o_rd_addr(o_rda32), .o_rd(o_rd32),
        .o_stall(stall32), .o_flush(flush32), .o_load_err(lerr32), .o_instret(ir32));

    writeback_stage_p #(.XLEN(64), .RADDR_W(5), .LOAD_TIMEOUT(4)) u64 (
        .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_funct3(f3), .i_opcode_load(ld),
        .i_opcode_system(sys), .i_addr_lo(alo), .i_dmem_data(data),
        .i_dmem_ack(ack), .i_csr_out(csr), .i_rd(rdv), .i_wr_rd(wr),
        .i_rd_addr(rda), .o_wr_rd(o_wr64), .o_rd_addr(o_rda64), .o_rd(o_rd64),
        .o_stall(stall64), .o_flush(flush64), .o_load_err(lerr64), .o_instret(ir64));

    typedef struct packed { logic [4:0] a; logic [63:0] d; } wr_t;
    wr_t q32[$];
    wr_t q64[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  n_ret = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference load semantics written from the ISA definition of each load.
    function automatic logic [63:0] ld_model(input int xl, input logic [2:0] f,
                                             input logic [63:0] d, input logic [2:0] a);
        logic [63:0] w;
        logic [63:0] r;
        int off;
        w   = (xl == 32) ? {32'b0, d[31:0]} : d;
        off = (xl == 32) ? int'(a[1:0]) : int'(a);
        w   = w >> (8 * off);
        case (f)
            3'b000:  r = {{56{w[7]}}, w[7:0]};
            3'b001:  r = {{48{w[15]}}, w[15:0]};
            3'b010:  r = {{32{w[31]}}, w[31:0]};
            3'b011:  r = (xl == 64) ? w : 64'd0;
            3'b100:  r = {56'd0, w[7:0]};
            3'b101:  r = {48'd0, w[15:0]};
            3'b110:  r = (xl == 64) ? {32'd0, w[31:0]} : 64'd0;
            default: r = 64'd0;
        endcase
        if (xl == 32) r[63:32] = 32'd0;
        return r;
    endfunction

    task automatic push(input logic [4:0] a, input logic [63:0] e32, input logic [63:0] e64,
                        input logic w);
        wr_t e;
        if (w && a != 5'd0) begin
            e.a = a; e.d = e32; q32.push_back(e);
            e.d = e64;          q64.push_back(e);
        end
    endtask

    // One clock: check stall mid-cycle (-1 = don't care), then writes and flush after the edge.
    task automatic cyc(input int exp_stall, input logic exp_flush);
        wr_t e;
        #2;
        if (exp_stall >= 0) begin
            chk("stall32", 64'(stall32), 64'(exp_stall));
            chk("stall64", 64'(stall64), 64'(exp_stall));
        end
        @(posedge clk); #1;
        if (q32.size() > 0) begin
            e = q32.pop_front();
            chk("wr32", 64'(o_wr32), 64'd1);
            chk("rda32", 64'(o_rda32), 64'(e.a));
            chk("rd32", 64'(o_rd32), e.d);
        end else chk("wr32_idle", 64'(o_wr32), 64'd0);
        if (q64.size() > 0) begin
            e = q64.pop_front();
            chk("wr64", 64'(o_wr64), 64'd1);
            chk("rda64", 64'(o_rda64), 64'(e.a));
            chk("rd64", o_rd64, e.d);
        end else chk("wr64_idle", 64'(o_wr64), 64'd0);
        chk("flush32", 64'(flush32), 64'(exp_flush));
        chk("lerr32", 64'(lerr32), 64'(exp_flush));
        chk("flush64", 64'(flush64), 64'(exp_flush));
        chk("lerr64", 64'(lerr64), 64'(exp_flush));
    endtask

    task automatic idle();
        ce = 1'b0; ld = 1'b0; sys = 1'b0; ack = 1'b0; wr = 1'b0;
    endtask

    task automatic alu(input logic [4:0] a, input logic [63:0] v, input logic w);
        ce = 1'b1; ld = 1'b0; sys = 1'b0; f3 = 3'b000; ack = 1'b0;
        rdv = v; csr = ~v; wr = w; rda = a;
        push(a, {32'd0, v[31:0]}, v, w);
        n_ret++;
        cyc(0, 1'b0);
    endtask

    task automatic csr_op(input logic [4:0] a, input logic [63:0] v);
        ce = 1'b1; ld = 1'b0; sys = 1'b1; f3 = 3'b010; ack = 1'b0;
        csr = v; rdv = ~v; wr = 1'b1; rda = a;
        push(a, {32'd0, v[31:0]}, v, 1'b1);
        n_ret++;
        cyc(0, 1'b0);
    endtask

    task automatic load_now(input logic [2:0] f, input logic [2:0] ao, input logic [63:0] d,
                            input logic [4:0] a, input logic [63:0] e32, input logic [63:0] e64);
        ce = 1'b1; ld = 1'b1; sys = 1'b0; ack = 1'b1; f3 = f; alo = ao;
        data = d; wr = 1'b1; rda = a; rdv = 64'h5A5A; csr = 64'hA5A5;
        push(a, e32, e64, 1'b1);
        n_ret++;
        cyc(0, 1'b0);
    endtask

    task automatic load_wait(input logic [2:0] f, input logic [2:0] ao, input logic [63:0] d,
                             input logic [4:0] a, input logic [63:0] e32, input logic [63:0] e64,
                             input int lat);
        ce = 1'b1; ld = 1'b1; sys = 1'b0; ack = 1'b0; f3 = f; alo = ao;
        data = {$urandom, $urandom}; wr = 1'b1; rda = a;
        cyc(1, 1'b0);
        for (int k = 1; k <= lat; k++) begin
            ce = 1'($urandom); ld = 1'($urandom); sys = 1'($urandom);
            f3 = 3'($urandom); alo = 3'($urandom); rda = 5'($urandom);
            wr = 1'($urandom); rdv = {$urandom, $urandom};
            if (k < lat) begin
                data = {$urandom, $urandom};
                cyc(1, 1'b0);
            end else begin
                ack = 1'b1; data = d;
                push(a, e32, e64, 1'b1);
                n_ret++;
                cyc(0, 1'b0);
            end
        end
        idle();
    endtask

    initial begin
        logic [63:0] d;
        logic [2:0]  f, ao;
        rst = 1'b1; idle(); f3 = '0; alo = '0; rda = '0; data = '0; csr = '0; rdv = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr32", 64'(o_wr32), 64'd0);
        chk("rst_rd32", 64'(o_rd32), 64'd0);
        chk("rst_rda64", 64'(o_rda64), 64'd0);
        chk("rst_rd64", o_rd64, 64'd0);
        chk("rst_err64", 64'(lerr64), 64'd0);
        chk("rst_stall32", 64'(stall32), 64'd0);
        chk("rst_instret32", ir32, 64'd0);
        chk("rst_instret64", ir64, 64'd0);
        rst = 1'b0;

        alu(5'd5, 64'h1234_5678, 1'b1);
        load_now(F3_LB,  3'd2, 64'h0080_0000, 5'd1, 64'hFFFF_FF80, 64'hFFFF_FFFF_FFFF_FF80);
        load_now(F3_LBU, 3'd2, 64'h0080_0000, 5'd2, 64'h0000_0080, 64'h0000_0000_0000_0080);
        load_now(F3_LH,  3'd2, 64'h8001_0000, 5'd3, 64'hFFFF_8001, 64'hFFFF_FFFF_FFFF_8001);
        load_wait(F3_LW, 3'd0, 64'h1357_9BDF, 5'd7, 64'h1357_9BDF, 64'h0000_0000_1357_9BDF, 3);

        // Timeout: no ack within LOAD_TIMEOUT, then a stray ack in IDLE.
        ce = 1'b1; ld = 1'b1; ack = 1'b0; f3 = F3_LW; rda = 5'd9; wr = 1'b1;
        cyc(1, 1'b0);
        ce = 1'b0;
        for (int k = 1; k < 4; k++) cyc(1, 1'b0);
        cyc(1, 1'b1);
        ack = 1'b1;
        cyc(0, 1'b0);
        idle();
        load_wait(F3_LHU, 3'd1, 64'hBEEF_CA00, 5'd10, 64'h0000_EFCA, 64'h0000_0000_0000_EFCA, 4);

        // Reset in WAIT drops the pending load; the late ack must not write.
        ce = 1'b1; ld = 1'b1; ack = 1'b0; f3 = F3_LW; rda = 5'd11; wr = 1'b1;
        cyc(1, 1'b0);
        ce = 1'b0;
        cyc(1, 1'b0);
        rst = 1'b1; n_ret = 0;
        cyc(-1, 1'b0);
        rst = 1'b0; ack = 1'b1; data = 64'hFFFF_FFFF;
        cyc(0, 1'b0);
        idle();

        alu(5'd0, 64'h77, 1'b1);
        load_now(F3_LW, 3'd0, 64'h1, 5'd0, 64'd0, 64'd0);
        alu(5'd9, 64'hCAFE_F00D, 1'b1);
        idle();
        cyc(0, 1'b0);
        cyc(0, 1'b0);
        chk("hold_rd32", 64'(o_rd32), 64'hCAFE_F00D);
        chk("hold_rda32", 64'(o_rda32), 64'd9);
        chk("hold_rd64", o_rd64, 64'hCAFE_F00D);

        for (int i = 0; i < 8; i++) begin
            d = {$urandom, $urandom}; f = 3'($urandom); ao = 3'($urandom);
            if (i % 2 == 0)
                load_now(f, ao, d, 5'(i + 12), ld_model(32, f, d, ao), ld_model(64, f, d, ao));
            else
                load_wait(f, ao, d, 5'(i + 12), ld_model(32, f, d, ao), ld_model(64, f, d, ao),
                          1 + (i % 4));
        end

        // Ten retired instructions from reset, including a stalled LD.
        rst = 1'b1; idle();
        cyc(-1, 1'b0);
        rst = 1'b0; n_ret = 0;
        alu(5'd1, 64'h11, 1'b1);
        alu(5'd2, 64'h22, 1'b1);
        csr_op(5'd3, 64'hDEAD_BEEF_0000_0033);
        alu(5'd0, 64'h44, 1'b1);
        alu(5'd4, 64'h55, 1'b0);
        sys = 1'b1;
        ce = 1'b1; ld = 1'b0; f3 = 3'b000; rdv = 64'h66; csr = 64'h99; wr = 1'b1; rda = 5'd5;
        push(5'd5, 64'h66, 64'h66, 1'b1); n_ret++;
        cyc(0, 1'b0);
        load_now(F3_LW, 3'd0, 64'h8000_0000, 5'd6, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000);
        load_wait(F3_LD, 3'd0, 64'h8000_0000_0000_0001, 5'd8, 64'd0, 64'h8000_0000_0000_0001, 2);
        load_now(F3_LBU, 3'd1, 64'hFF00, 5'd10, 64'hFF, 64'hFF);
        alu(5'd11, 64'hABCD, 1'b1);
        idle();
        cyc(0, 1'b0);
`ifdef WB_INSTRET_EN
        chk("instret32", ir32, 64'(n_ret));
        chk("instret64", ir64, 64'd10);
`else
        chk("instret32_off", ir32, 64'd0);
        chk("instret64_off", ir64, 64'd0);
`endif
        load_now(F3_LWU, 3'd0, 64'hFFFF_FFFF, 5'd12, 64'd0, 64'h0000_0000_FFFF_FFFF);
        idle();
        cyc(0, 1'b0);
        chk("sb_empty", 64'(q32.size() + q64.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
